// File: rtl/updi_phy_mc.sv
// UPDI half-duplex PHY: 12-bit frames (start, 8 data LSB first, even parity, 2 stop),
// double-break generation, and a line receiver that is muted while the PHY drives.
module updi_phy_mc #(
  parameter int unsigned DIV_W         = 16,
  parameter int unsigned BREAK_CLK     = 100000,
  parameter int unsigned BREAK_GAP_CLK = 1000,
  parameter int unsigned GAP_W         = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [DIV_W-1:0] baud_div,
  input  logic [GAP_W-1:0] tx_gap,
  input  logic [7:0]       tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic [7:0]       rx_data,
  output logic             rx_valid,
  output logic             rx_parity_err,
  output logic             rx_frame_err,
  output logic             rx_break,
  input  logic             break_start,
  output logic             break_done,
  output logic             busy,
  input  logic             updi_in,
  output logic             updi_drive_low
);

  localparam logic [31:0] BRK_LO_LAST = BREAK_CLK - 1;
  localparam logic [31:0] BRK_HI_LAST = BREAK_GAP_CLK - 1;

  typedef enum logic [2:0] {IDLE, TX, GAP, BRK_LO1, BRK_HI1, BRK_LO2, BRK_HI2} state_e;

  state_e           r_state, w_state_nxt;
  logic [31:0]      r_cnt, r_gap_last;
  logic [3:0]       r_bit;
  logic [11:0]      r_shift;
  logic [DIV_W-1:0] r_tx_div;
  logic             r_brk_pend, r_break_done;

  logic [DIV_W-1:0] w_div_eff;
  logic             w_tx_bit_end, w_tx_last, w_accept;

  assign w_div_eff    = (baud_div < DIV_W'(4)) ? DIV_W'(4) : baud_div;
  assign w_tx_bit_end = (r_cnt == 32'(r_tx_div) - 32'd1);
  assign w_tx_last    = (r_state == TX) && w_tx_bit_end && (r_bit == 4'd11);
  assign w_accept     = tx_valid & tx_ready;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (break_start) w_state_nxt = BRK_LO1;
               else if (w_accept) w_state_nxt = TX;
      TX:      if (w_tx_last) begin
                 if (r_brk_pend || break_start) w_state_nxt = BRK_LO1;
                 else if (tx_gap != '0)         w_state_nxt = GAP;
                 else                           w_state_nxt = IDLE;
               end
      GAP:     if (r_brk_pend || break_start) w_state_nxt = BRK_LO1;
               else if (r_cnt == r_gap_last)  w_state_nxt = IDLE;
      BRK_LO1: if (r_cnt == BRK_LO_LAST) w_state_nxt = BRK_HI1;
      BRK_HI1: if (r_cnt == BRK_HI_LAST) w_state_nxt = BRK_LO2;
      BRK_LO2: if (r_cnt == BRK_LO_LAST) w_state_nxt = BRK_HI2;
      BRK_HI2: if (r_cnt == BRK_HI_LAST) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_gap_last   <= '0;
      r_bit        <= '0;
      r_shift      <= '1;
      r_tx_div     <= DIV_W'(4);
      r_brk_pend   <= 1'b0;
      r_break_done <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_break_done <= (r_state == BRK_HI2) && (w_state_nxt == IDLE);
      if (r_state != w_state_nxt || (r_state == TX && w_tx_bit_end) || r_state == IDLE) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 32'd1;
      end
      if (w_state_nxt == BRK_LO1 && r_state != BRK_LO1) begin
        r_brk_pend <= 1'b0;
      end else if (break_start && (r_state == TX || r_state == GAP)) begin
        r_brk_pend <= 1'b1;
      end
      if (w_accept) begin
        r_shift  <= {2'b11, ^tx_data, tx_data, 1'b0};
        r_bit    <= '0;
        r_tx_div <= w_div_eff;
      end else if (r_state == TX && w_tx_bit_end && r_bit != 4'd11) begin
        r_shift <= {1'b1, r_shift[11:1]};
        r_bit   <= r_bit + 4'd1;
      end
      // IDLE's accept cycle supplies the final cycle of the last gap period.
      if (w_tx_last) r_gap_last <= 32'(tx_gap) * 32'(r_tx_div) - 32'd2;
    end
  end

  always_comb begin
    updi_drive_low = 1'b0;
    case (r_state)
      TX:               updi_drive_low = ~r_shift[0];
      BRK_LO1, BRK_LO2: updi_drive_low = 1'b1;
      default:          updi_drive_low = 1'b0;
    endcase
  end

  // Receiver
  logic             r_sync1, r_sync2, r_rx_prev, r_rx_act;
  logic [DIV_W-1:0] r_rx_cnt, r_rx_div;
  logic [3:0]       r_rx_bit;
  logic [11:0]      r_rx_sh;
  logic             w_rx_en, w_rx_samp, w_rx_last, w_rx_start;
  logic [11:0]      w_rx_frame;

  assign w_rx_en    = (r_state == IDLE) || (r_state == GAP);
  assign w_rx_samp  = r_rx_act && (r_rx_cnt == '0);
  assign w_rx_last  = w_rx_samp && (r_rx_bit == 4'd11);
  assign w_rx_frame = {r_sync2, r_rx_sh[11:1]};
  assign w_rx_start = w_rx_en && r_rx_prev && !r_sync2 && (!r_rx_act || w_rx_last);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1       <= 1'b1;
      r_sync2       <= 1'b1;
      r_rx_prev     <= 1'b1;
      r_rx_act      <= 1'b0;
      r_rx_cnt      <= '0;
      r_rx_div      <= DIV_W'(4);
      r_rx_bit      <= '0;
      r_rx_sh       <= '0;
      rx_data       <= '0;
      rx_valid      <= 1'b0;
      rx_parity_err <= 1'b0;
      rx_frame_err  <= 1'b0;
      rx_break      <= 1'b0;
    end else begin
      r_sync1   <= updi_in;
      r_sync2   <= r_sync1;
      r_rx_prev <= r_sync2;
      rx_valid  <= 1'b0;
      rx_break  <= 1'b0;
      if (w_rx_en && w_rx_last) begin
        if (w_rx_frame == '0) begin
          rx_break <= 1'b1;
        end else begin
          rx_valid      <= 1'b1;
          rx_data       <= w_rx_frame[8:1];
          rx_parity_err <= ^w_rx_frame[9:1];
          rx_frame_err  <= ~&w_rx_frame[11:10];
        end
      end
      if (!w_rx_en) begin
        r_rx_act <= 1'b0;
      end else if (w_rx_start) begin
        r_rx_act <= 1'b1;
        r_rx_cnt <= (w_div_eff >> 1) - DIV_W'(1);
        r_rx_div <= w_div_eff;
        r_rx_bit <= '0;
      end else if (w_rx_samp) begin
        if (r_rx_bit == 4'd0 && r_sync2) begin
          r_rx_act <= 1'b0;
        end else begin
          r_rx_sh  <= w_rx_frame;
          r_rx_cnt <= r_rx_div - DIV_W'(1);
          r_rx_bit <= r_rx_bit + 4'd1;
          if (r_rx_bit == 4'd11) r_rx_act <= 1'b0;
        end
      end else if (r_rx_act) begin
        r_rx_cnt <= r_rx_cnt - DIV_W'(1);
      end
    end
  end

  assign tx_ready   = rst_n && (r_state == IDLE) && !r_brk_pend && !break_start && !r_rx_act;
  assign break_done = r_break_done;
  assign busy       = (r_state != IDLE) || r_rx_act;

endmodule
